// File: rtl/seq_divider.sv
// Sequential restoring (shift-subtract) unsigned divider, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero reports all-ones quotient and the dividend as remainder.
module seq_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_dvd;
    logic [N-1:0]  r_dvs;
    logic [N-1:0]  r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_r;
    logic          r_dbz;

    logic          w_accept;
    logic          w_dvs_zero;
    logic          w_last;
    logic [N:0]    w_rem_sh;
    logic [N:0]    w_diff;
    logic          w_ge;
    logic [N-1:0]  w_rem_nxt;
    logic [N-1:0]  w_dvd_shift;

    // Request acceptance and one restoring-division step on the (N+1)-bit partial remainder.
    always_comb begin
        w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_dvs_zero  = (r_dvs == {N{1'b0}});
        w_last      = (r_cnt == CW'(1));
        w_rem_sh    = {r_rem, r_dvd[N-1]};
        w_diff      = w_rem_sh - {1'b0, r_dvs};
        w_ge        = (w_rem_sh >= {1'b0, r_dvs});
        // When the subtract is skipped, the shifted remainder is below b and its top bit is 0.
        if (w_ge) begin
            w_rem_nxt = w_diff[N-1:0];
        end else begin
            w_rem_nxt = w_rem_sh[N-1:0];
        end
        w_dvd_shift = {r_dvd[N-2:0], w_ge};
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_dvs_zero || w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration datapath and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= {N{1'b0}};
            r_dvs  <= {N{1'b0}};
            r_rem  <= {N{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_q    <= {N{1'b0}};
            r_r    <= {N{1'b0}};
            r_dbz  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_dvd  <= a;
                        r_dvs  <= b;
                        r_rem  <= {N{1'b0}};
                        r_cnt  <= CW'(N);
                        r_busy <= 1'b1;
                        r_q    <= {N{1'b0}};
                        r_r    <= {N{1'b0}};
                        r_dbz  <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_dvs_zero) begin
                        r_q    <= {N{1'b1}};
                        r_r    <= r_dvd;
                        r_dbz  <= 1'b1;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        // Quotient bits shift into the vacated LSBs of the dividend register.
                        r_dvd <= w_dvd_shift;
                        r_rem <= w_rem_nxt;
                        r_cnt <= r_cnt - CW'(1);
                        if (w_last) begin
                            r_q    <= w_dvd_shift;
                            r_r    <= w_rem_nxt;
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_busy <= 1'b1;
                            r_done <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign q           = r_q;
    assign r           = r_r;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive bench for seq_divider (N=4) with a result scoreboard.
module tb_seq_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] q;
    logic [3:0] r;
    logic       div_by_zero;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int z;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total    = 0;
    int   bad      = 0;
    int   n_issued = 0;
    int   n_done   = 0;
    int   lat;
    int   nd0;

    seq_divider #(.N(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive a request (accepted on the next rising edge) and record its expected result.
    task automatic issue(input int ia, input int ib);
        exp_t e;
        start = 1'b1;
        a     = 4'(ia);
        b     = 4'(ib);
        e.a   = ia;
        e.b   = ib;
        e.q   = (ib == 0) ? 15 : ia / ib;
        e.r   = (ib == 0) ? ia : ia % ib;
        e.z   = (ib == 0) ? 1 : 0;
        sb.push_back(e);
        n_issued++;
    endtask

    // Count falling edges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            n = i + 1;
            if (done) break;
        end
        chk("done_seen", int'(done), 1);
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            chk("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                m_e = sb.pop_front();
                chk("q", int'(q), m_e.q);
                chk("r", int'(r), m_e.r);
                chk("dbz", int'(div_by_zero), m_e.z);
                if (m_e.b != 0) begin
                    chk("inv_eq", int'(q) * m_e.b + int'(r), m_e.a);
                    chk("inv_lt", int'(int'(r) < m_e.b), 1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // 13/3 cycle-accurate handshake
        issue(13, 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("t1_busy", int'(busy), 1);
            chk("t1_done_early", int'(done), 0);
        end
        @(negedge clk);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_done", int'(done), 1);
        @(negedge clk);
        chk("t1_done_pulse", int'(done), 0);
        chk("t1_q_hold", int'(q), 4);
        chk("t1_r_hold", int'(r), 1);

        // 15/1, one idle cycle, then 2/9
        issue(15, 1);
        wait_done(lat);
        chk("t2_lat", lat, 5);
        @(negedge clk);
        chk("t2_q_hold", int'(q), 15);
        issue(2, 9);
        wait_done(lat);
        chk("t2b_lat", lat, 5);

        // divide by zero
        @(negedge clk);
        issue(7, 0);
        @(negedge clk);
        start = 1'b0;
        chk("t3_busy", int'(busy), 1);
        chk("t3_done_early", int'(done), 0);
        @(negedge clk);
        chk("t3_busy_end", int'(busy), 0);
        chk("t3_done", int'(done), 1);

        // start while busy is ignored, then back-to-back on the DONE cycle
        @(negedge clk);
        issue(13, 3);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd6; b = 4'd2;
        @(negedge clk);
        start = 1'b0; a = 4'd0; b = 4'd0;
        chk("t4_busy", int'(busy), 1);
        wait_done(lat);
        chk("t4_lat_rest", lat, 2);
        issue(6, 2);
        @(negedge clk);
        start = 1'b0;
        chk("t4_q_cleared", int'(q), 0);
        chk("t4_busy_b2b", int'(busy), 1);
        wait_done(lat);
        chk("t4_lat_b2b", lat, 4);

        // asynchronous reset mid-run
        @(negedge clk);
        issue(11, 2);
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_q", int'(q), 0);
        chk("t5_r", int'(r), 0);
        chk("t5_dbz", int'(div_by_zero), 0);
        sb.delete();
        n_issued--;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd0 = n_done;
        repeat (8) @(negedge clk);
        chk("t5_no_done", n_done - nd0, 0);
        chk("t5_idle_busy", int'(busy), 0);
        issue(11, 2);
        wait_done(lat);
        chk("t5_lat", lat, 5);

        // exhaustive sweep, back-to-back
        @(negedge clk);
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                issue(ia, ib);
                wait_done(lat);
                chk("sweep_lat", lat, (ib == 0) ? 2 : 5);
            end
        end
        repeat (3) @(negedge clk);
        chk("done_count", n_done, n_issued);
        chk("sb_empty", int'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
